button_conditioner: RTL



---
 rtl/board_pkg.sv | 19 +
 rtl/button_conditioner_if.sv | 33 +++
 rtl/sync_debounce.sv | 55 +++++
 rtl/button_conditioner.sv | 115 +++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared board-level definitions for the push-button front end.
// Holds the clock rate, a ms->cycles helper and the press FSM state type.
// No logic here; everything is elaborated at compile time.
package board_pkg;

    localparam int CLK_HZ = 12000000;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } btn_state_t;

    // Converts a duration in milliseconds to a cycle count at CLK_HZ.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Bundles a raw button pin with its conditioned level and event pulses.
// Latency and timing are set by the conditioner driving the slave side.
// No backpressure: every event is a single-cycle pulse the consumer must catch.
interface button_conditioner_if;

    logic btn_raw;
    logic pressed;
    logic press;
    logic released;
    logic click;
    logic long_press;

    // Board/sequencer side: drives the pin, consumes level and events.
    modport master (
        output btn_raw,
        input  pressed,
        input  press,
        input  released,
        input  click,
        input  long_press
    );

    // Conditioner side: samples the pin, produces level and events.
    modport slave (
        input  btn_raw,
        output pressed,
        output press,
        output released,
        output click,
        output long_press
    );

endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchronizer plus integrating debouncer for one button pin.
// Latency: a clean pin edge moves `stable` exactly 2 + DEBOUNCE_CYCLES clocks later.
// No backpressure; `accept` strobes for one cycle in the cycle before `stable` flips.
module sync_debounce #(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic stable,
    output logic accept
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          s;
    logic [CW-1:0] cnt;

    // Resynchronise the asynchronous pin; reset loads the idle pin level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Normalised sample: 1 always means "button pushed" regardless of pin polarity.
    assign s = sync2 ^ ACTIVE_LOW;

    // Next edge will commit the new level; lets the FSM move in lockstep with `stable`.
    assign accept = (s != stable) && (cnt == CNT_LAST);

    // Integrate disagreement; any agreeing sample wipes the run, so glitches leave no credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (s == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= s;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Turns one raw push-button pin into a debounced level plus press/release/click/long_press pulses.
// Latency: pressed/press/released/click follow a clean pin edge by 2 + DEBOUNCE_CYCLES clocks.
// No backpressure; each event is a one-cycle pulse, long_press lands LONG_CYCLES-1 after press.
module button_conditioner
    import board_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = ms_to_cycles(10),
    parameter int LONG_CYCLES     = ms_to_cycles(1000)
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);

    localparam int            HW        = $clog2(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic          stable;
    logic          accept;
    logic          rise;
    logic          fall;

    btn_state_t    state_q;
    btn_state_t    state_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic          press_q;
    logic          press_d;
    logic          rel_q;
    logic          rel_d;
    logic          click_q;
    logic          click_d;
    logic          long_comb;

    sync_debounce #(
        .ACTIVE_LOW      (ACTIVE_LOW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn_raw),
        .stable  (stable),
        .accept  (accept)
    );

    // Debounced edges as seen one cycle early, so registered pulses line up with `pressed`.
    assign rise = accept & ~stable;
    assign fall = accept &  stable;

    // Classify the press; a release accepted on the last hold count beats long_press.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        rel_d     = 1'b0;
        click_d   = 1'b0;
        long_comb = 1'b0;
        case (state_q)
            RELEASED: begin
                if (rise) begin
                    state_d = PRESSED;
                    hold_d  = '0;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (fall) begin
                    state_d = RELEASED;
                    rel_d   = 1'b1;
                    click_d = 1'b1;
                end else if (hold_q == HOLD_LAST) begin
                    long_comb = 1'b1;
                    state_d   = HELD;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            HELD: begin
                // Hold count stays frozen here; only a release can leave.
                if (fall) begin
                    state_d = RELEASED;
                    rel_d   = 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    // State, hold count and registered event pulses; reset silences everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RELEASED;
            hold_q  <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            click_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            click_q <= click_d;
        end
    end

    assign bus.pressed    = stable;
    assign bus.press      = press_q;
    assign bus.released   = rel_q;
    assign bus.click      = click_q;
    assign bus.long_press = long_comb;

endmodule
